// File: rtl/branch_seq_pkg.sv
// Shared constants, state encoding and strobe bundle for the branch/jump sequencer.
package branch_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned CNT_W  = 16;

    localparam logic [OPC_W-1:0] OPC_BR  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_JR  = 5'b10100;
    localparam logic [OPC_W-1:0] OPC_JAL = 5'b10011;

    localparam logic [1:0] BRZR = 2'b00;
    localparam logic [1:0] BRNZ = 2'b01;
    localparam logic [1:0] BRPL = 2'b10;
    localparam logic [1:0] BRMI = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RA   = 3'd1,
        PCY  = 3'd2,
        ADD  = 3'd3,
        WB   = 3'd4,
        LINK = 3'd5,
        JMP  = 3'd6,
        DONE = 3'd7
    } state_t;

    // Control strobes driven onto the shared-bus datapath in one step.
    typedef struct packed {
        logic gra;
        logic rout;
        logic pc_out;
        logic pc_in;
        logic y_in;
        logic c_out;
        logic z_in;
        logic zlo_out;
        logic alu_add;
        logic link_in;
    } strobe_t;

    function automatic logic is_supported(input logic [OPC_W-1:0] opc);
        return (opc == OPC_BR) || (opc == OPC_JR) || (opc == OPC_JAL);
    endfunction

    // First step after IDLE; unsupported opcodes go straight to DONE.
    function automatic state_t dispatch_state(input logic [OPC_W-1:0] opc);
        state_t s;
        s = DONE;
        if (opc == OPC_BR) begin
            s = RA;
        end else if (opc == OPC_JR) begin
            s = JMP;
        end else if (opc == OPC_JAL) begin
            s = LINK;
        end
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Control/bus interface of the branch sequencer. BRANCH_STATS_EN adds the branch statistics counters.
interface branch_sequencer_if;
    import branch_seq_pkg::*;

    logic              start;
    logic [DATA_W-1:0] ir;
    logic              stall;
    logic [DATA_W-1:0] bus_data;

    logic busy;
    logic done;
    logic illegal;
    logic gra;
    logic rout;
    logic pc_out;
    logic pc_in;
    logic y_in;
    logic c_out;
    logic z_in;
    logic zlo_out;
    logic alu_add;
    logic link_in;
    logic taken;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_taken_cnt;
    logic [CNT_W-1:0] br_nottaken_cnt;
`endif

    modport master (
        output start, ir, stall, bus_data,
        input  busy, done, illegal, gra, rout, pc_out, pc_in, y_in, c_out,
               z_in, zlo_out, alu_add, link_in, taken
`ifdef BRANCH_STATS_EN
        , input br_taken_cnt, br_nottaken_cnt
`endif
    );

    modport slave (
        input  start, ir, stall, bus_data,
        output busy, done, illegal, gra, rout, pc_out, pc_in, y_in, c_out,
               z_in, zlo_out, alu_add, link_in, taken
`ifdef BRANCH_STATS_EN
        , output br_taken_cnt, br_nottaken_cnt
`endif
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: condition code from IR against the register value on the bus.
module branch_cond_eval
    import branch_seq_pkg::*;
(
    input  logic [1:0]        cc,
    input  logic [DATA_W-1:0] value,
    output logic              cond_c
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value == '0);
    assign is_neg  = value[DATA_W-1];

    always_comb begin
        cond_c = 1'b0;
        case (cc)
            BRZR: cond_c = is_zero;
            BRNZ: cond_c = !is_zero;
            BRPL: cond_c = !is_neg && !is_zero;
            BRMI: cond_c = is_neg;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch/jump control FSM (br, jr, jal) stepping the shared bus through T3..T6.
// Define BRANCH_STATS_EN to add saturating taken/not-taken branch counters.
module branch_sequencer
    import branch_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    branch_sequencer_if.slave sif
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              con_q, con_d;
    logic              cond_c;
    strobe_t           stb_c;
    logic              busy_c;
    logic              done_c;
    logic              illegal_c;
    logic [OPC_W-1:0]  opc_q;
    logic              ir_unused_c;

    assign opc_q       = ir_q[DATA_W-1 -: OPC_W];
    assign ir_unused_c = ^{ir_q[DATA_W-OPC_W-1:21], ir_q[18:0]};

    branch_cond_eval u_cond (
        .cc     (ir_q[20:19]),
        .value  (sif.bus_data),
        .cond_c (cond_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            con_q   <= con_d;
        end
    end

    // Next state and Moore strobes; a stalled step holds and drives nothing.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        con_d     = con_q;
        stb_c     = '0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    ir_d    = sif.ir;
                    state_d = dispatch_state(sif.ir[DATA_W-1 -: OPC_W]);
                end
            end
            RA: begin
                busy_c = 1'b1;
                if (!sif.stall) begin
                    stb_c.gra  = 1'b1;
                    stb_c.rout = 1'b1;
                    con_d      = cond_c;
                    state_d    = PCY;
                end
            end
            PCY: begin
                busy_c = 1'b1;
                if (!sif.stall) begin
                    stb_c.pc_out = 1'b1;
                    stb_c.y_in   = 1'b1;
                    state_d      = ADD;
                end
            end
            ADD: begin
                busy_c = 1'b1;
                if (!sif.stall) begin
                    stb_c.c_out   = 1'b1;
                    stb_c.alu_add = 1'b1;
                    stb_c.z_in    = 1'b1;
                    state_d       = WB;
                end
            end
            WB: begin
                busy_c = 1'b1;
                if (!sif.stall) begin
                    // Not taken: Z is still driven, but PC keeps its fetch-time PC+1.
                    stb_c.zlo_out = 1'b1;
                    stb_c.pc_in   = con_q;
                    state_d       = DONE;
                end
            end
            LINK: begin
                busy_c = 1'b1;
                if (!sif.stall) begin
                    stb_c.pc_out  = 1'b1;
                    stb_c.link_in = 1'b1;
                    state_d       = JMP;
                end
            end
            JMP: begin
                busy_c = 1'b1;
                if (!sif.stall) begin
                    stb_c.gra   = 1'b1;
                    stb_c.rout  = 1'b1;
                    stb_c.pc_in = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                illegal_c = !is_supported(opc_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sif.busy    = busy_c;
    assign sif.done    = done_c;
    assign sif.illegal = illegal_c;
    assign sif.gra     = stb_c.gra;
    assign sif.rout    = stb_c.rout;
    assign sif.pc_out  = stb_c.pc_out;
    assign sif.pc_in   = stb_c.pc_in;
    assign sif.y_in    = stb_c.y_in;
    assign sif.c_out   = stb_c.c_out;
    assign sif.z_in    = stb_c.z_in;
    assign sif.zlo_out = stb_c.zlo_out;
    assign sif.alu_add = stb_c.alu_add;
    assign sif.link_in = stb_c.link_in;
    assign sif.taken   = con_q;

`ifdef BRANCH_STATS_EN
    logic             wb_exit_c;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;
    logic [CNT_W-1:0] ntk_cnt_q, ntk_cnt_d;

    assign wb_exit_c = (state_q == WB) && !sif.stall;

    // Count each completed branch once, on the cycle it leaves WB.
    always_comb begin
        tk_cnt_d  = tk_cnt_q;
        ntk_cnt_d = ntk_cnt_q;
        if (wb_exit_c) begin
            if (con_q) begin
                tk_cnt_d = sat_inc(tk_cnt_q);
            end else begin
                ntk_cnt_d = sat_inc(ntk_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tk_cnt_q  <= '0;
            ntk_cnt_q <= '0;
        end else begin
            tk_cnt_q  <= tk_cnt_d;
            ntk_cnt_q <= ntk_cnt_d;
        end
    end

    assign sif.br_taken_cnt    = tk_cnt_q;
    assign sif.br_nottaken_cnt = ntk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized self-checking bench for branch_sequencer against a per-instruction step-list model.
module tb_branch_sequencer;

    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JR  = 5'b10100;
    localparam logic [4:0] OP_JAL = 5'b10011;
    localparam logic [4:0] OP_BAD = 5'b11111;

    // Strobe masks: {gra,rout,pc_out,pc_in,y_in,c_out,z_in,zlo_out,alu_add,link_in}
    localparam logic [9:0] M_RA   = 10'b1100000000;
    localparam logic [9:0] M_PCY  = 10'b0010100000;
    localparam logic [9:0] M_ADD  = 10'b0000011010;
    localparam logic [9:0] M_WB   = 10'b0000000100;
    localparam logic [9:0] M_PCIN = 10'b0001000000;
    localparam logic [9:0] M_LINK = 10'b0010000001;
    localparam logic [9:0] M_JMP  = 10'b1101000000;

    logic        clk;
    logic        reset;
    logic        exp_taken;
    logic [13:0] obs;
    int          n_vec = 0;
    int          n_bad = 0;
`ifdef BRANCH_STATS_EN
    int          exp_tk  = 0;
    int          exp_ntk = 0;
`endif

    branch_sequencer_if bif ();

    branch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .sif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bif.busy, bif.done, bif.illegal, bif.taken,
                  bif.gra, bif.rout, bif.pc_out, bif.pc_in, bif.y_in,
                  bif.c_out, bif.z_in, bif.zlo_out, bif.alu_add, bif.link_in};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_cond(input logic [1:0] cc, input logic [31:0] v);
        case (cc)
            2'd0:    return v == 32'd0;
            2'd1:    return v != 32'd0;
            2'd2:    return $signed(v) > 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    function automatic logic rnd_bit(input int pct);
        int r;
        r = int'($urandom_range(99, 0));
        return r < pct;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [1:0] cc);
        return {opc, 6'h00, cc, 19'd5};
    endfunction

    // One instruction from the idle cycle that starts it to its done cycle.
    task automatic run_instr(input logic [31:0] ir, input logic [31:0] rv, input int stall_pct,
                             input int hold_step, input int hold_len);
        logic [9:0] steps[$];
        logic [4:0] opc;
        logic       ill;
        logic       con;
        logic       stl;
        int         held;
        opc = ir[31:27];
        ill = 1'b0;
        con = model_cond(ir[20:19], rv);
        if (opc == OP_BR)       steps = '{M_RA, M_PCY, M_ADD, con ? (M_WB | M_PCIN) : M_WB};
        else if (opc == OP_JAL) steps = '{M_LINK, M_JMP};
        else if (opc == OP_JR)  steps = '{M_JMP};
        else                    ill = 1'b1;

        @(negedge clk);
        bif.start    = 1'b1;
        bif.ir       = ir;
        bif.stall    = rnd_bit(stall_pct);
        bif.bus_data = $urandom;
        #1 check_eq($sformatf("idle_op%0h", opc), 32'(obs), 32'({3'b000, exp_taken, 10'b0}));

        for (int i = 0; i < steps.size(); i++) begin
            held = 0;
            forever begin
                @(negedge clk);
                bif.start = rnd_bit(50);
                bif.ir    = $urandom;
                stl = (i == hold_step && held < hold_len) ? 1'b1 : rnd_bit(stall_pct);
                bif.stall    = stl;
                bif.bus_data = (steps[i] == M_RA && !stl) ? rv : $urandom;
                #1;
                if (stl) begin
                    check_eq($sformatf("stall_op%0h_s%0d", opc, i), 32'(obs),
                             32'({3'b100, exp_taken, 10'b0}));
                    held++;
                end else begin
                    check_eq($sformatf("step_op%0h_s%0d", opc, i), 32'(obs),
                             32'({3'b100, exp_taken, steps[i]}));
                    if (opc == OP_BR && i == 0) exp_taken = con;
`ifdef BRANCH_STATS_EN
                    if (opc == OP_BR && i == 3) begin
                        if (con) exp_tk++;
                        else     exp_ntk++;
                    end
`endif
                    break;
                end
            end
        end

        @(negedge clk);
        bif.start = rnd_bit(50);
        bif.ir    = $urandom;
        bif.stall = rnd_bit(stall_pct);
        #1 check_eq($sformatf("done_op%0h", opc), 32'(obs), 32'({2'b01, ill, exp_taken, 10'b0}));
    endtask

    initial begin
        logic [31:0] vals[6];
        logic [4:0]  opc;
        logic [31:0] rv;
        int          sel;

        reset        = 1'b1;
        bif.start    = 1'b0;
        bif.ir       = '0;
        bif.stall    = 1'b0;
        bif.bus_data = '0;
        exp_taken    = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_eq("reset", 32'(obs), 32'd0);
        reset = 1'b0;

        run_instr(mk_ir(OP_BR, 2'd0), 32'h0000_0000, 0, -1, 0);
        run_instr(mk_ir(OP_BR, 2'd1), 32'h0000_0000, 0, -1, 0);
        run_instr(mk_ir(OP_BR, 2'd3), 32'h8000_0000, 0, -1, 0);
        run_instr(mk_ir(OP_BR, 2'd2), 32'h0000_0000, 0, -1, 0);
        run_instr(mk_ir(OP_BR, 2'd2), 32'h0000_0001, 0, -1, 0);
        run_instr(mk_ir(OP_JAL, 2'd0), 32'h0, 0, -1, 0);
        run_instr(mk_ir(OP_JR, 2'd0), 32'h0, 0, -1, 0);
        run_instr(mk_ir(OP_BAD, 2'd0), 32'h0, 0, -1, 0);
        run_instr(mk_ir(OP_BR, 2'd1), 32'h0000_0007, 0, 2, 3);
        run_instr(mk_ir(OP_JR, 2'd0), 32'h0, 0, 0, 2);

        // Reset asserted mid-sequence in PCY, then a full branch afterwards.
        @(negedge clk);
        bif.start = 1'b1;
        bif.ir    = mk_ir(OP_BR, 2'd0);
        bif.stall = 1'b0;
        #1 check_eq("rst_idle", 32'(obs), 32'({3'b000, exp_taken, 10'b0}));
        @(negedge clk);
        bif.start    = 1'b0;
        bif.bus_data = 32'h0;
        #1 check_eq("rst_ra", 32'(obs), 32'({3'b100, exp_taken, M_RA}));
        exp_taken = 1'b1;
        @(negedge clk);
        #1 check_eq("rst_pcy", 32'(obs), 32'({3'b100, exp_taken, M_PCY}));
        #1 reset = 1'b1;
        #1 check_eq("rst_async", 32'(obs), 32'd0);
        exp_taken = 1'b0;
`ifdef BRANCH_STATS_EN
        exp_tk  = 0;
        exp_ntk = 0;
`endif
        @(negedge clk);
        reset = 1'b0;
        run_instr(mk_ir(OP_BR, 2'd0), 32'h0, 0, -1, 0);

        vals = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        for (int k = 0; k < 80; k++) begin
            sel = int'($urandom_range(4, 0));
            case (sel)
                0, 1: opc = OP_BR;
                2:    opc = OP_JR;
                3:    opc = OP_JAL;
                default: begin
                    opc = 5'($urandom);
                    while (opc == OP_BR || opc == OP_JR || opc == OP_JAL) opc = 5'($urandom);
                end
            endcase
            vals[5] = $urandom;
            rv = vals[$urandom_range(5, 0)];
            run_instr({opc, 27'($urandom)}, rv, 30, -1, 0);
        end

`ifdef BRANCH_STATS_EN
        #1 check_eq("stats_taken", 32'(bif.br_taken_cnt), 32'((exp_tk > 65535) ? 65535 : exp_tk));
        check_eq("stats_nottaken", 32'(bif.br_nottaken_cnt), 32'((exp_ntk > 65535) ? 65535 : exp_ntk));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
